traffic_light_controller: RTL and testbench
===========================================

Name: traffic_light_controller

Overview:
- Main/side-road intersection sequencer with a pedestrian walk phase, stepped by the 1 Hz enable pulse from divider (enable_1Hz).
- Sits between divider and the lamp drivers. Latches vehicle and pedestrian demand, enforces minimum main-green, yellow, all-red and walk durations counted in seconds.

Parameters:
T_MAIN_GREEN, 10, minimum main-road green (s); green is held beyond this until demand exists
T_YELLOW, 3, yellow duration (s), both roads
T_ALL_RED, 1, all-red clearance after a yellow (s)
T_SIDE_GREEN, 6, side-road green duration (s)
T_WALK, 5, pedestrian walk duration (s)
T_PED_CLEAR, 2, all-red clearance after walk (s)
(all 1..255)

Ports:
clock  in  1  system clock
reset_sync  in  1  synchronous reset, active-low
enable_1Hz  in  1  one-clock tick from divider, 1 per second
side_request  in  1  side-road vehicle sensor (level)
ped_request  in  1  pedestrian button (any width pulse)
main_lights  out  3  {red,yellow,green} for main road
side_lights  out  3  {red,yellow,green} for side road
walk  out  1  pedestrian walk lamp
side_pending  out  1  latched side demand
ped_pending  out  1  latched pedestrian demand
phase_time  out  8  seconds elapsed in current state

Behaviour:
- One clock; every register updates on rising clock. reset_sync=0 at an edge: state=MG, phase_time=0, side_pending=0, ped_pending=0. Reset wins over every other input, including mid-phase.
- Reset outputs: main_lights=001, side_lights=100, walk=0.
- States (3-bit): MG, MY, AR1, SG, SY, AR2, WALK, PCLR.
- Lamp decode (combinational from the state register):
  - MG: main 001, side 100.
  - MY: main 010, side 100.
  - SG: main 100, side 001.
  - SY: main 100, side 010.
  - AR1/AR2/PCLR: both 100.
  - WALK: both 100, walk=1.
  - walk=0 in all other states.
- Timer:
  - On enable_1Hz with no transition: phase_time increments, saturating at 255.
  - On a transition: phase_time <= 0.
  - Without enable_1Hz: phase_time holds.
  - Transitions occur only on cycles with enable_1Hz=1. "Expires(T)" means enable_1Hz=1 and phase_time==T-1.
- Transitions:
  - MG -> MY: enable_1Hz=1, phase_time>=T_MAIN_GREEN-1, and (side_pending or ped_pending). With no demand, MG holds indefinitely.
  - MY -> AR1: expires(T_YELLOW).
  - AR1 -> SG if side_pending, else -> WALK. Taken on expires(T_ALL_RED).
  - SG -> SY: expires(T_SIDE_GREEN).
  - SY -> AR2: expires(T_YELLOW).
  - AR2 -> WALK if ped_pending, else -> MG. Taken on expires(T_ALL_RED).
  - WALK -> PCLR: expires(T_WALK).
  - PCLR -> MG: expires(T_PED_CLEAR).
- Demand latches:
  - side_pending is set on any cycle with side_request=1 and cleared on the transition edge into SG.
  - ped_pending is set on any cycle with ped_request=1 and cleared on the transition edge into WALK.
  - If set and clear coincide, set wins, so no request is lost; that demand is served in the next round.
- Latency:
  - Lamps change on the clock edge that registers the transition, i.e. the edge sampling the qualifying tick.
  - A demand latches one edge after its input is seen.
- Safety invariant: main and side are never both non-red. walk=1 only while both are red.

Test Plan:
(Parameters for all scenarios: T_MAIN_GREEN=4, T_YELLOW=2, T_ALL_RED=1, T_SIDE_GREEN=3, T_WALK=2, T_PED_CLEAR=1. enable_1Hz is a 1-clock pulse every 4 clocks.)
1. Reset, no requests, 20 ticks -> state stays MG; main_lights=001, side_lights=100, walk=0; phase_time=20.
2. side_request held high from tick 1 -> sequence MG(4 ticks), MY(2), AR1(1), SG(3), SY(2), AR2(1), MG. side_pending clears on SG entry and re-sets while the input stays high. Invariant holds throughout.
3. Single-cycle ped_request only -> sequence MG(4), MY(2), AR1(1), WALK(2, walk=1, both 100), PCLR(1), MG. ped_pending cleared at WALK entry.
4. side_request and ped_request both asserted before tick 4 -> sequence MG, MY, AR1, SG, SY, AR2, WALK, PCLR, MG. Both pendings clear at their respective entries.
5. ped_request on the exact cycle of WALK entry -> ped_pending remains 1 after entry; an extra pedestrian round follows the next MG minimum.
6. reset_sync=0 mid-SG (phase_time=1), coincident with enable_1Hz=1 -> next edge gives state MG, phase_time=0, both pendings 0, main_lights=001, side_lights=100.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Main/side-road intersection sequencer with a pedestrian walk phase.
// All phase durations are counted in seconds of enable_1Hz ticks; lamps are registered.
module traffic_light_controller #(
    parameter int unsigned T_MAIN_GREEN = 10,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 1,
    parameter int unsigned T_SIDE_GREEN = 6,
    parameter int unsigned T_WALK       = 5,
    parameter int unsigned T_PED_CLEAR  = 2
) (
    input  logic       clock,
    input  logic       reset_sync,
    input  logic       enable_1Hz,
    input  logic       side_request,
    input  logic       ped_request,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic       side_pending,
    output logic       ped_pending,
    output logic [7:0] phase_time
);

    typedef enum logic [2:0] {
        S_MG   = 3'd0,
        S_MY   = 3'd1,
        S_AR1  = 3'd2,
        S_SG   = 3'd3,
        S_SY   = 3'd4,
        S_AR2  = 3'd5,
        S_WALK = 3'd6,
        S_PCLR = 3'd7
    } state_t;

    localparam logic [7:0] LIM_MG   = 8'(T_MAIN_GREEN - 1);
    localparam logic [7:0] LIM_Y    = 8'(T_YELLOW - 1);
    localparam logic [7:0] LIM_AR   = 8'(T_ALL_RED - 1);
    localparam logic [7:0] LIM_SG   = 8'(T_SIDE_GREEN - 1);
    localparam logic [7:0] LIM_WALK = 8'(T_WALK - 1);
    localparam logic [7:0] LIM_PCLR = 8'(T_PED_CLEAR - 1);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    state_t     state_q, state_d;
    logic [7:0] phase_time_q, phase_time_d;
    logic       side_pending_q, side_pending_d;
    logic       ped_pending_q, ped_pending_d;
    logic [2:0] main_lights_q, main_lights_d;
    logic [2:0] side_lights_q, side_lights_d;
    logic       walk_q, walk_d;
    logic       leave_s;

    // Next-state, timer, demand latches and lamp decode of the upcoming state
    always_comb begin
        state_d = state_q;
        if (enable_1Hz) begin
            case (state_q)
                S_MG: begin
                    if ((phase_time_q >= LIM_MG) && (side_pending_q || ped_pending_q)) begin
                        state_d = S_MY;
                    end else begin
                        state_d = S_MG;
                    end
                end
                S_MY:   state_d = (phase_time_q == LIM_Y)    ? S_AR1  : S_MY;
                S_AR1: begin
                    if (phase_time_q == LIM_AR) begin
                        state_d = side_pending_q ? S_SG : S_WALK;
                    end else begin
                        state_d = S_AR1;
                    end
                end
                S_SG:   state_d = (phase_time_q == LIM_SG)   ? S_SY   : S_SG;
                S_SY:   state_d = (phase_time_q == LIM_Y)    ? S_AR2  : S_SY;
                S_AR2: begin
                    if (phase_time_q == LIM_AR) begin
                        state_d = ped_pending_q ? S_WALK : S_MG;
                    end else begin
                        state_d = S_AR2;
                    end
                end
                S_WALK: state_d = (phase_time_q == LIM_WALK) ? S_PCLR : S_WALK;
                S_PCLR: state_d = (phase_time_q == LIM_PCLR) ? S_MG   : S_PCLR;
                default: state_d = S_MG;
            endcase
        end else begin
            state_d = state_q;
        end

        // Every transition goes to a different state, so a change of state marks a transition
        leave_s = (state_d != state_q);

        if (!enable_1Hz) begin
            phase_time_d = phase_time_q;
        end else if (leave_s) begin
            phase_time_d = 8'd0;
        end else if (phase_time_q != 8'd255) begin
            phase_time_d = phase_time_q + 8'd1;
        end else begin
            phase_time_d = phase_time_q;
        end

        side_pending_d = side_request | (side_pending_q & ~(leave_s & (state_d == S_SG)));
        ped_pending_d  = ped_request  | (ped_pending_q  & ~(leave_s & (state_d == S_WALK)));

        walk_d = 1'b0;
        case (state_d)
            S_MG: begin
                main_lights_d = LAMP_GREEN;
                side_lights_d = LAMP_RED;
            end
            S_MY: begin
                main_lights_d = LAMP_YELLOW;
                side_lights_d = LAMP_RED;
            end
            S_SG: begin
                main_lights_d = LAMP_RED;
                side_lights_d = LAMP_GREEN;
            end
            S_SY: begin
                main_lights_d = LAMP_RED;
                side_lights_d = LAMP_YELLOW;
            end
            S_WALK: begin
                main_lights_d = LAMP_RED;
                side_lights_d = LAMP_RED;
                walk_d        = 1'b1;
            end
            default: begin
                main_lights_d = LAMP_RED;
                side_lights_d = LAMP_RED;
            end
        endcase
    end

    // State, timer, demand and lamp registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_sync) begin
            state_q        <= S_MG;
            phase_time_q   <= 8'd0;
            side_pending_q <= 1'b0;
            ped_pending_q  <= 1'b0;
            main_lights_q  <= LAMP_GREEN;
            side_lights_q  <= LAMP_RED;
            walk_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_time_q   <= phase_time_d;
            side_pending_q <= side_pending_d;
            ped_pending_q  <= ped_pending_d;
            main_lights_q  <= main_lights_d;
            side_lights_q  <= side_lights_d;
            walk_q         <= walk_d;
        end
    end

    assign main_lights  = main_lights_q;
    assign side_lights  = side_lights_q;
    assign walk         = walk_q;
    assign side_pending = side_pending_q;
    assign ped_pending  = ped_pending_q;
    assign phase_time   = phase_time_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: directed scenarios plus random demand,
// every cycle compared against a phase-table reference model.
module tb_traffic_light_controller;

    logic       clock = 1'b0;
    logic       reset_sync = 1'b0;
    logic       enable_1Hz = 1'b0;
    logic       side_request = 1'b0;
    logic       ped_request = 1'b0;
    logic [2:0] main_lights, side_lights;
    logic       walk, side_pending, ped_pending;
    logic [7:0] phase_time;

    int total = 0;
    int bad = 0;
    int walk_cycles = 0;
    int side_green_cycles = 0;

    traffic_light_controller #(
        .T_MAIN_GREEN(4), .T_YELLOW(2), .T_ALL_RED(1),
        .T_SIDE_GREEN(3), .T_WALK(2), .T_PED_CLEAR(1)
    ) dut (
        .clock(clock), .reset_sync(reset_sync), .enable_1Hz(enable_1Hz),
        .side_request(side_request), .ped_request(ped_request),
        .main_lights(main_lights), .side_lights(side_lights), .walk(walk),
        .side_pending(side_pending), .ped_pending(ped_pending), .phase_time(phase_time)
    );

    always #5 clock = ~clock;

    // Reference model: phase name, seconds in phase, latched demands
    localparam int P_MG = 0, P_MY = 1, P_AR1 = 2, P_SG = 3, P_SY = 4, P_AR2 = 5, P_WALK = 6, P_PCLR = 7;
    int dur [8] = '{4, 2, 1, 3, 2, 1, 2, 1};
    int m_phase = P_MG;
    int m_t = 0;
    bit m_sp = 1'b0;
    bit m_pp = 1'b0;

    function automatic int succ(input int p, input bit sp, input bit pp);
        case (p)
            P_MG:    return P_MY;
            P_MY:    return P_AR1;
            P_AR1:   return sp ? P_SG : P_WALK;
            P_SG:    return P_SY;
            P_SY:    return P_AR2;
            P_AR2:   return pp ? P_WALK : P_MG;
            P_WALK:  return P_PCLR;
            default: return P_MG;
        endcase
    endfunction

    function automatic logic [2:0] main_of(input int p);
        if (p == P_MG) return 3'b001;
        if (p == P_MY) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] side_of(input int p);
        if (p == P_SG) return 3'b001;
        if (p == P_SY) return 3'b010;
        return 3'b100;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit en, input bit sr, input bit pr, input bit rst);
        bit leave;
        int nxt;
        enable_1Hz   = en;
        side_request = sr;
        ped_request  = pr;
        reset_sync   = rst;
        if (!rst) begin
            m_phase = P_MG; m_t = 0; m_sp = 1'b0; m_pp = 1'b0;
        end else begin
            if (m_phase == P_MG)
                leave = en && (m_t >= dur[P_MG] - 1) && (m_sp || m_pp);
            else
                leave = en && (m_t == dur[m_phase] - 1);
            nxt  = leave ? succ(m_phase, m_sp, m_pp) : m_phase;
            m_sp = (m_sp && !(leave && nxt == P_SG)) || sr;
            m_pp = (m_pp && !(leave && nxt == P_WALK)) || pr;
            if (leave) m_t = 0;
            else if (en && m_t < 255) m_t++;
            m_phase = nxt;
        end
        @(posedge clock);
        #1;
        if (walk === 1'b1) walk_cycles++;
        if (side_lights === 3'b001) side_green_cycles++;
        check("main_lights", {5'd0, main_lights}, {5'd0, main_of(m_phase)});
        check("side_lights", {5'd0, side_lights}, {5'd0, side_of(m_phase)});
        check("walk", {7'd0, walk}, {7'd0, (m_phase == P_WALK)});
        check("side_pending", {7'd0, side_pending}, {7'd0, m_sp});
        check("ped_pending", {7'd0, ped_pending}, {7'd0, m_pp});
        check("phase_time", phase_time, 8'(m_t));
        check("one_road_red", {7'd0, (main_lights[2] | side_lights[2])}, 8'd1);
        check("walk_all_red", {7'd0, (!walk | (main_lights[2] & side_lights[2]))}, 8'd1);
    endtask

    // One second: tick on the first clock, side level held, ped pulse on the first clock only
    task automatic tick(input bit sr, input bit pr, input bit rst);
        step(1'b1, sr, pr, rst);
        repeat (3) step(1'b0, sr, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        walk_cycles = 0;
        side_green_cycles = 0;
    endtask

    initial begin
        bit found;

        // 1: idle, MG holds and counts
        do_reset();
        check("s1_reset_main", {5'd0, main_lights}, 8'h01);
        check("s1_reset_time", phase_time, 8'd0);
        repeat (20) tick(1'b0, 1'b0, 1'b1);
        check("s1_time20", phase_time, 8'd20);
        check("s1_main", {5'd0, main_lights}, 8'h01);

        // 2: side demand for five seconds, one side round
        do_reset();
        repeat (5) tick(1'b1, 1'b0, 1'b1);
        repeat (15) tick(1'b0, 1'b0, 1'b1);
        check("s2_side_green_cycles", 8'(side_green_cycles), 8'd12);
        check("s2_no_walk", 8'(walk_cycles), 8'd0);

        // 3: single-cycle pedestrian press
        do_reset();
        tick(1'b0, 1'b1, 1'b1);
        repeat (14) tick(1'b0, 1'b0, 1'b1);
        check("s3_walk_cycles", 8'(walk_cycles), 8'd8);
        check("s3_no_side_green", 8'(side_green_cycles), 8'd0);

        // 4: both demands
        do_reset();
        tick(1'b1, 1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b0, 1'b1);
        check("s4_walk_cycles", 8'(walk_cycles), 8'd8);
        check("s4_side_green_cycles", 8'(side_green_cycles), 8'd12);

        // 5: press coinciding with the WALK entry edge
        do_reset();
        tick(1'b0, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_phase == P_AR1) found = 1'b1;
            else tick(1'b0, 1'b0, 1'b1);
        end
        check("s5_reached_ar1", {7'd0, found}, 8'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("s5_walk_on", {7'd0, walk}, 8'd1);
        check("s5_ped_kept", {7'd0, ped_pending}, 8'd1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (25) tick(1'b0, 1'b0, 1'b1);
        check("s5_two_walk_rounds", 8'(walk_cycles), 8'd16);

        // 6: reset in mid-SG at phase_time 1, coincident with a tick
        do_reset();
        tick(1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_phase == P_SG && m_t == 1) found = 1'b1;
            else tick(1'b1, 1'b0, 1'b1);
        end
        check("s6_reached_sg1", {7'd0, found}, 8'd1);
        check("s6_pre_side", {5'd0, side_lights}, 8'h01);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("s6_main", {5'd0, main_lights}, 8'h01);
        check("s6_side", {5'd0, side_lights}, 8'h04);
        check("s6_time", phase_time, 8'd0);
        check("s6_pend", {6'd0, side_pending, ped_pending}, 8'd0);

        // Random demand and occasional reset
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 59) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
